noc_inject_arbiter: RTL
=======================

Name: noc_inject_arbiter

Overview:
- Shares one NoC router injection port (r_valid_pe / r_data_pe / r_ready_pe of one PE) between NUM_SRC local traffic sources.
- Round-robin arbitration, a one-entry registered output stage and an injection-rate limiter (minimum RATE cycles between issued packets).
- Sits between the per-PE traffic generators and openNocTop. Counts injected packets for throughput/efficiency reporting.

Parameters:
- X, 10: mesh columns; used only to size the default flit width.
- Y, 10: mesh rows; used only to size the default flit width.
- data_width, 256: payload bits per packet.
- x_size, $clog2(X): destination X field width.
- y_size, $clog2(Y): destination Y field width.
- NUM_SRC, 4: number of local requesters, range 1..16.
- RATE, 1: minimum cycles between successive latches into the output stage, range 1..255.
- Derived: TW = x_size+y_size+data_width (flit width, carried opaquely). IW = max(1,$clog2(NUM_SRC)).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  allow new grants; the held packet still drains when low.
- src_valid  in  NUM_SRC  per-source packet request.
- src_data  in  NUM_SRC*TW  per-source flit; source i at [i*TW +: TW].
- src_ready  out  NUM_SRC  one-hot grant/accept; source i's flit is consumed in a cycle where src_valid[i] & src_ready[i].
- r_valid_pe  out  1  flit valid toward router.
- r_data_pe  out  TW  flit toward router.
- r_ready_pe  in  1  router accepts the flit.
- last_src  out  IW  index of the source of the flit currently or most recently held.
- sent_count  out  32  flits accepted by router since reset; wraps at 2^32.
- busy  out  1  r_valid_pe | (|src_valid).

Behaviour:
- Reset (async, rstn=0): r_valid_pe=0, r_data_pe=0, src_ready=0, last_src=0, sent_count=0, rate counter=0, round-robin pointer=NUM_SRC-1 (so source 0 has first priority).
- Output stage states: EMPTY (r_valid_pe=0) and FULL (r_valid_pe=1).
- can_load is true when all of these hold: enable=1, rate counter==0, and (state==EMPTY or r_ready_pe=1).
- Grant (combinational):
  - When can_load and some src_valid is set, src_ready is one-hot on the first valid source searching ptr+1, ptr+2, ... modulo NUM_SRC.
  - Otherwise src_ready=0.
  - src_ready never asserts for a source whose src_valid=0.
- On a grant edge:
  - r_data_pe <= src_data of the granted source; r_valid_pe <= 1; last_src and ptr <= granted index.
  - Rate counter <= RATE-1.
- Rate counter decrements by 1 each cycle while nonzero, saturating at 0. Successive latches are therefore spaced at least RATE cycles apart.
- FULL: r_valid_pe and r_data_pe are held stable until r_ready_pe=1. No change while r_ready_pe=0, regardless of enable or src_valid.
- Accept (r_valid_pe & r_ready_pe):
  - sent_count increments by 1.
  - If a grant happens in the same cycle, the stage reloads (back-to-back; with RATE=1 throughput is 1 flit/cycle). Otherwise the state becomes EMPTY.
- Latency: source handshake at edge N gives r_valid_pe=1 from cycle N+1. This is a registered path; there is no combinational path src_valid to r_valid_pe.
- Combinational path r_ready_pe to src_ready exists; this is intended.
- enable falling while FULL: the held flit completes normally and no further grants are made. enable rising resumes from the current ptr.
- NUM_SRC=1: src_ready[0] = can_load & src_valid[0]; ptr stays 0.
- Reset mid-operation: the held flit is discarded and the router sees r_valid_pe drop asynchronously. Sources must re-present.
- X or Z on src_valid is illegal; the bench flags it.

Test Plan:
- Reset then idle: rstn low 5 cycles, then high with src_valid=0 -> r_valid_pe=0, src_ready=0, sent_count=0, busy=0.
- Round-robin fairness: NUM_SRC=4, RATE=1, all src_valid=1, r_ready_pe=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; sent_count=8 one cycle after the last grant, then 8; r_valid_pe stays high continuously.
- Backpressure: src0 presents flit 0xA5 (low byte), r_ready_pe=0 for 6 cycles -> r_data_pe stable at 0xA5, src_ready=0 throughout, sent_count unchanged; r_ready_pe=1 -> sent_count+1.
- Rate limit: RATE=4, src2 always valid, r_ready_pe=1 -> src_ready[2] pulses every 4th cycle; after 40 cycles sent_count=10 (±1).
- Enable gating: while FULL, drop enable and hold r_ready_pe=1 -> held flit accepted, no further src_ready until enable=1; resume grants the source after last_src.
- Mid-packet reset: assert rstn=0 while FULL with r_ready_pe=0 -> r_valid_pe=0 immediately (asynchronously, before the next clock edge); after release, first grant goes to source 0.

Source files
------------

// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter: shares one router injection port between NUM_SRC sources
// through a single registered flit stage, with a minimum spacing of RATE cycles between loads.
module noc_inject_arbiter #(
  parameter int unsigned X          = 10,
  parameter int unsigned Y          = 10,
  parameter int unsigned data_width = 256,
  parameter int unsigned x_size     = $clog2(X),
  parameter int unsigned y_size     = $clog2(Y),
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned RATE       = 1,
  localparam int unsigned TW        = x_size + y_size + data_width,
  localparam int unsigned IW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*TW-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic                  r_valid_pe,
  output logic [TW-1:0]         r_data_pe,
  input  logic                  r_ready_pe,
  output logic [IW-1:0]         last_src,
  output logic [31:0]           sent_count,
  output logic                  busy
);

  localparam int unsigned RW = 8;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [RW-1:0]      rate_cnt;

  logic               can_load_c;
  logic               grant_c;
  logic [NUM_SRC-1:0] hi_c;
  logic [NUM_SRC-1:0] sel_vec_c;
  logic [IW-1:0]      pick_c;
  logic [TW-1:0]      data_c;

  // Sources strictly above ptr win first; otherwise wrap to the lowest valid source.
  always_comb begin
    hi_c       = src_valid & ~((NUM_SRC'(2) << ptr) - NUM_SRC'(1));
    sel_vec_c  = (|hi_c) ? hi_c : src_valid;
    pick_c     = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (sel_vec_c[i]) pick_c = IW'(i);
    end
    data_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (pick_c == IW'(i)) data_c = src_data[i*TW +: TW];
    end
  end

  // The stage can take a new flit when empty or draining this cycle.
  assign can_load_c = enable && (rate_cnt == '0) && ((state == EMPTY) || r_ready_pe);
  assign grant_c    = can_load_c && (|src_valid);
  assign src_ready  = grant_c ? (NUM_SRC'(1) << pick_c) : '0;

  assign r_valid_pe = (state == FULL);
  assign busy       = r_valid_pe | (|src_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= EMPTY;
      r_data_pe  <= '0;
      last_src   <= '0;
      ptr        <= IW'(NUM_SRC - 1);
      rate_cnt   <= '0;
      sent_count <= '0;
    end else begin
      if (rate_cnt != '0) rate_cnt <= rate_cnt - RW'(1);
      if ((state == FULL) && r_ready_pe) begin
        sent_count <= sent_count + 32'd1;
        state      <= EMPTY;
      end
      // A grant in the accept cycle reloads the stage back-to-back.
      if (grant_c) begin
        state     <= FULL;
        r_data_pe <= data_c;
        last_src  <= pick_c;
        ptr       <= pick_c;
        rate_cnt  <= RW'(RATE - 1);
      end
    end
  end

endmodule
